rotate_func: RTL

ROTATE_FUNC -- requirements
Module: rotate_func

---
 rtl/rotate_func.sv | 117 +++++++++++
 1 files changed

// File: rtl/rotate_func.sv
// rotate_func: per-lane z-rotation of a 64-slice 5x5 state.
// Buffers 64 slices, then streams each slice back with every lane rotated.
module rotate_func #(
  parameter int LINES = 64,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int AW = $clog2(LINES);
  localparam logic [AW-1:0] LAST = AW'(LINES - 1);

  // Rotation offset of lane (x,y), indexed by bit i = 5*x + y.
  localparam int ROT [25] = '{
     0, 36,  3, 41, 18,
     1, 44, 10, 45,  2,
    62,  6, 43, 15, 61,
    28, 55, 25, 21, 56,
    27, 20, 39,  8, 14
  };

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] in_cnt;
  logic [AW-1:0] out_cnt;
  logic [W-1:0]  mem [LINES];
  logic [W-1:0]  rot_data;
  logic          in_xfer;
  logic          out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Slice buffer: written only while loading, never reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      mem[in_cnt] <= in_data;
    end
  end

  // Each lane bit reads its own slice, out_cnt minus its offset, mod 64.
  for (genvar i = 0; i < W; i++) begin : g_rot
    logic [AW-1:0] addr;
    assign addr        = out_cnt - AW'(ROT[i]);
    assign rot_data[i] = mem[addr][i];
  end

  // Output is forced to zero outside EMIT so reset clears it at once.
  assign out_data = out_valid ? rot_data : '0;

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_cnt   <= '0;
            out_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == LAST) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_xfer) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LAST) begin
              state     <= FIN;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
